// File: rtl/nios_system_sysid_checker.sv
// nios_system_sysid_checker
// Avalon-MM read master that reads the system-ID slave (word 0 = ID, word 1 =
// build timestamp) after reset or on a start pulse, compares both words with
// their build-time values and latches the results for boot-ready gating.
module nios_system_sysid_checker #(
   parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
   parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1480469370,
   parameter int          READ_LATENCY       = 0,
   parameter int          TIMEOUT_CYCLES     = 255,
   parameter bit          AUTO_START         = 1'b1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic [31:0] avm_readdata,
   input  logic        avm_waitrequest,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        timeout,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      REQ_ID = 3'd1,
      LAT_ID = 3'd2,
      REQ_TS = 3'd3,
      LAT_TS = 3'd4,
      FIN    = 3'd5
   } state_t;

   // Latency counter is loaded with (latency - 1) on accept so it reaches zero
   // on the cycle whose closing edge is the capture edge.
   localparam bit          HAS_LAT  = (READ_LATENCY > 0);
   localparam logic [1:0]  LAT_LOAD = 2'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);
   localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);

   state_t      state, state_nxt;
   logic        auto_pend;
   logic [1:0]  lat_cnt;
   logic [15:0] to_cnt;

   logic        launch;
   logic        accept;
   logic        stall_out;
   logic        cap_id;
   logic        cap_ts;

   function automatic logic word_match(input logic [31:0] word, input logic [31:0] ref_word);
      return (word == ref_word);
   endfunction

   assign launch    = (state == IDLE) && (start || auto_pend);
   assign accept    = avm_read && !avm_waitrequest;
   assign stall_out = avm_read && avm_waitrequest && (to_cnt == TO_LAST);
   assign cap_id    = ((state == REQ_ID) && accept && !HAS_LAT) ||
                      ((state == LAT_ID) && (lat_cnt == 2'd0));
   assign cap_ts    = ((state == REQ_TS) && accept && !HAS_LAT) ||
                      ((state == LAT_TS) && (lat_cnt == 2'd0));

   // State register plus the one-shot auto-start flag armed by reset.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state     <= IDLE;
         auto_pend <= AUTO_START;
      end else begin
         state     <= state_nxt;
         auto_pend <= 1'b0;
      end
   end

   // Next-state selection; a stall timeout skips whatever read remains.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:   if (launch) state_nxt = REQ_ID;
         REQ_ID: begin
            if (accept)         state_nxt = HAS_LAT ? LAT_ID : REQ_TS;
            else if (stall_out) state_nxt = FIN;
         end
         LAT_ID: if (lat_cnt == 2'd0) state_nxt = REQ_TS;
         REQ_TS: begin
            if (accept)         state_nxt = HAS_LAT ? LAT_TS : FIN;
            else if (stall_out) state_nxt = FIN;
         end
         LAT_TS: if (lat_cnt == 2'd0) state_nxt = FIN;
         FIN:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Bus strobes and status decoded from the state; address is 1 only around the TS read.
   always_comb begin
      avm_read    = (state == REQ_ID) || (state == REQ_TS);
      avm_address = (state == REQ_TS) || (state == LAT_TS);
      busy        = (state == REQ_ID) || (state == LAT_ID) ||
                    (state == REQ_TS) || (state == LAT_TS);
      done        = (state == FIN);
   end

   // Read-latency countdown and per-read stall counter.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         lat_cnt <= 2'd0;
         to_cnt  <= 16'd0;
      end else begin
         if (accept)
            lat_cnt <= LAT_LOAD;
         else if (((state == LAT_ID) || (state == LAT_TS)) && (lat_cnt != 2'd0))
            lat_cnt <= lat_cnt - 2'd1;

         if (launch || accept)
            to_cnt <= 16'd0;
         else if (avm_read && avm_waitrequest)
            to_cnt <= to_cnt + 16'd1;
      end
   end

   // Result flags and captured words; cleared when a new sequence starts.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         id_ok    <= 1'b0;
         ts_ok    <= 1'b0;
         timeout  <= 1'b0;
         id_value <= 32'd0;
         ts_value <= 32'd0;
      end else if (launch) begin
         id_ok    <= 1'b0;
         ts_ok    <= 1'b0;
         timeout  <= 1'b0;
         id_value <= 32'd0;
         ts_value <= 32'd0;
      end else begin
         if (cap_id) begin
            id_value <= avm_readdata;
            id_ok    <= word_match(avm_readdata, EXPECTED_ID);
         end
         if (cap_ts) begin
            ts_value <= avm_readdata;
            ts_ok    <= word_match(avm_readdata, EXPECTED_TIMESTAMP);
         end
         if (stall_out)
            timeout <= 1'b1;
      end
   end

endmodule

// File: tb/tb_nios_system_sysid_checker.sv
// Bench for nios_system_sysid_checker: two instances (zero-latency defaults,
// and latency 2 / timeout 8 / manual start) driven by a plan-based slave and
// checked every cycle against a timeline model derived from read plans.
`timescale 1ns/1ps
module tb_nios_system_sysid_checker;

   localparam logic [31:0] EID0 = 32'h0000_0000;
   localparam logic [31:0] ETS0 = 32'd1480469370;
   localparam logic [31:0] EID1 = 32'hCAFE_0001;
   localparam logic [31:0] ETS1 = 32'h1234_5678;
   localparam int L1 = 2;
   localparam int T0 = 255;
   localparam int T1 = 8;

   typedef struct {
      int w0, w1, to0, to1, re0, dv0, s1, re1, dv1, fin;
      logic [31:0] d0, d1;
   } plan_t;

   typedef struct packed {
      logic rd, addr, busy, done, id_ok, ts_ok, tmo;
      logic [31:0] idv, tsv;
   } out_t;

   typedef struct {
      string       name;
      logic [31:0] got, want;
   } lit_t;

   logic        clock = 1'b0;
   logic        reset_n [2];
   logic        start [2];
   logic        avm_address [2];
   logic        avm_read [2];
   logic [31:0] avm_readdata [2];
   logic        avm_waitrequest [2];
   logic        busy [2];
   logic        done [2];
   logic        id_ok [2];
   logic        ts_ok [2];
   logic        timeout [2];
   logic [31:0] id_value [2];
   logic [31:0] ts_value [2];

   out_t exp_o [2];
   out_t hold [2];
   out_t act_c;
   bit   chk_en = 1'b0;
   int   checks = 0;
   int   errors = 0;
   lit_t lit_q [64];
   int   lit_wr = 0;
   int   lit_rd = 0;

   always #5 clock = ~clock;

   nios_system_sysid_checker u_dut0 (
      .clock(clock), .reset_n(reset_n[0]), .start(start[0]),
      .avm_address(avm_address[0]), .avm_read(avm_read[0]),
      .avm_readdata(avm_readdata[0]), .avm_waitrequest(avm_waitrequest[0]),
      .busy(busy[0]), .done(done[0]), .id_ok(id_ok[0]), .ts_ok(ts_ok[0]),
      .timeout(timeout[0]), .id_value(id_value[0]), .ts_value(ts_value[0])
   );

   nios_system_sysid_checker #(
      .EXPECTED_ID(EID1), .EXPECTED_TIMESTAMP(ETS1), .READ_LATENCY(L1),
      .TIMEOUT_CYCLES(T1), .AUTO_START(1'b0)
   ) u_dut1 (
      .clock(clock), .reset_n(reset_n[1]), .start(start[1]),
      .avm_address(avm_address[1]), .avm_read(avm_read[1]),
      .avm_readdata(avm_readdata[1]), .avm_waitrequest(avm_waitrequest[1]),
      .busy(busy[1]), .done(done[1]), .id_ok(id_ok[1]), .ts_ok(ts_ok[1]),
      .timeout(timeout[1]), .id_value(id_value[1]), .ts_value(ts_value[1])
   );

   function automatic int lat_of(input int d);
      return (d == 0) ? 0 : L1;
   endfunction
   function automatic int tmo_of(input int d);
      return (d == 0) ? T0 : T1;
   endfunction
   function automatic logic [31:0] eid(input int d);
      return (d == 0) ? EID0 : EID1;
   endfunction
   function automatic logic [31:0] ets(input int d);
      return (d == 0) ? ETS0 : ETS1;
   endfunction

   // Timeline of one sequence, in cycles counted from the start-sampling edge.
   // Each read occupies (stalls + 1) request cycles plus the latency cycles;
   // data is sampled at the end of the last of those cycles.
   function automatic plan_t mk_plan(input int d, input int w0, input int w1,
                                     input logic [31:0] d0, input logic [31:0] d1);
      plan_t p;
      int L, T;
      L = lat_of(d);
      T = tmo_of(d);
      p.w0 = w0; p.w1 = w1; p.d0 = d0; p.d1 = d1;
      p.to0 = (w0 >= T) ? 1 : 0;
      p.re0 = p.to0 ? T : 1 + w0;
      p.dv0 = 1 + w0 + L;
      p.s1  = p.dv0 + 1;
      if (p.to0 != 0) begin
         p.fin = T + 1; p.to1 = 0; p.re1 = -1; p.dv1 = -1;
      end else begin
         p.to1 = (w1 >= T) ? 1 : 0;
         p.re1 = p.to1 ? p.s1 + T - 1 : p.s1 + w1;
         p.dv1 = p.s1 + w1 + L;
         p.fin = p.to1 ? p.s1 + T : p.dv1 + 1;
      end
      return p;
   endfunction

   function automatic out_t eval(input int d, input plan_t p, input int r);
      out_t o;
      o = '0;
      o.rd   = (r >= 1 && r <= p.re0) || (p.to0 == 0 && r >= p.s1 && r <= p.re1);
      o.addr = (p.to0 == 0) && r >= p.s1 && r < p.fin;
      o.busy = (r >= 1) && (r < p.fin);
      o.done = (r == p.fin);
      if (p.to0 == 0 && r > p.dv0) begin
         o.idv = p.d0; o.id_ok = (p.d0 == eid(d));
      end
      if (p.to0 == 0 && p.to1 == 0 && r > p.dv1) begin
         o.tsv = p.d1; o.ts_ok = (p.d1 == ets(d));
      end
      o.tmo = (p.to0 != 0 || p.to1 != 0) && r >= p.fin;
      return o;
   endfunction

   function automatic out_t act_of(input int d);
      out_t o;
      o.rd = avm_read[d]; o.addr = avm_address[d]; o.busy = busy[d]; o.done = done[d];
      o.id_ok = id_ok[d]; o.ts_ok = ts_ok[d]; o.tmo = timeout[d];
      o.idv = id_value[d]; o.tsv = ts_value[d];
      return o;
   endfunction

   task automatic lit(input string n, input logic [31:0] g, input logic [31:0] w);
      lit_q[lit_wr].name = n;
      lit_q[lit_wr].got  = g;
      lit_q[lit_wr].want = w;
      lit_wr++;
   endtask

   // Slave: stalls for the planned count on each read, presents the word only
   // on the cycle it must be sampled, noise everywhere else.
   task automatic drive_slave(input int d, input plan_t p, input int r);
      if (r >= 1 && r <= p.re0)
         avm_waitrequest[d] = (r - 1 < p.w0);
      else if (p.to0 == 0 && r >= p.s1 && r <= p.re1)
         avm_waitrequest[d] = (r - p.s1 < p.w1);
      else
         avm_waitrequest[d] = 1'($urandom % 2);
      if (p.to0 == 0 && r == p.dv0)
         avm_readdata[d] = p.d0;
      else if (p.to0 == 0 && p.to1 == 0 && r == p.dv1)
         avm_readdata[d] = p.d1;
      else
         avm_readdata[d] = $urandom;
   endtask

   task automatic run_trial(input int d, input int launch, input plan_t p,
                            input int abort_r, input int poke,
                            output int done_r, output int rd_cnt,
                            output int done_cnt, output int addr1_cnt, output int aborted);
      done_r = -1; rd_cnt = 0; done_cnt = 0; addr1_cnt = 0; aborted = 0;
      if (launch != 0) begin
         reset_n[d] = 1'b0;
         start[d]   = 1'b0;
         repeat (2) begin
            @(posedge clock); #1;
            exp_o[d] = '0;
         end
         start[d] = 1'($urandom % 2);
         @(posedge clock); #1;
         exp_o[d]   = '0;
         hold[d]    = '0;
         reset_n[d] = 1'b1;
         start[d]   = (d == 0) ? 1'($urandom % 2) : 1'b1;
      end else begin
         start[d] = 1'b1;
      end
      for (int r = 0; r <= p.fin; r++) begin
         exp_o[d] = (r == 0) ? hold[d] : eval(d, p, r);
         drive_slave(d, p, r);
         if (r > 0) start[d] = (poke != 0) ? ($urandom % 3 == 0) : 1'b0;
         if (done[d] === 1'b1) begin
            done_cnt++;
            if (done_r < 0) done_r = r;
         end
         if (avm_read[d] === 1'b1) rd_cnt++;
         if (avm_read[d] === 1'b1 && avm_address[d] === 1'b1) addr1_cnt++;
         if (abort_r > 0 && r == abort_r) begin
            reset_n[d] = 1'b0;
            start[d]   = 1'b0;
            @(posedge clock); #1;
            exp_o[d] = '0;
            hold[d]  = '0;
            aborted  = 1;
            return;
         end
         @(posedge clock); #1;
      end
      hold[d]  = eval(d, p, p.fin + 1);
      exp_o[d] = hold[d];
      start[d] = 1'b0;
      avm_waitrequest[d] = 1'($urandom % 2);
   endtask

   // Compare process: pinned literals first, then every DUT output every cycle.
   initial begin
      forever begin
         @(negedge clock);
         while (lit_rd < lit_wr) begin
            checks++;
            if (lit_q[lit_rd].got !== lit_q[lit_rd].want) begin
               errors++;
               $display("FAIL %s got %0d (0x%h) expected %0d (0x%h)", lit_q[lit_rd].name,
                        lit_q[lit_rd].got, lit_q[lit_rd].got, lit_q[lit_rd].want, lit_q[lit_rd].want);
            end
            lit_rd++;
         end
         if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
               act_c = act_of(d);
               checks++;
               if (act_c !== exp_o[d]) begin
                  errors++;
                  $display("FAIL dut%0d outputs t=%0t got rd=%b ad=%b bsy=%b dn=%b iok=%b tok=%b to=%b id=%h ts=%h expected rd=%b ad=%b bsy=%b dn=%b iok=%b tok=%b to=%b id=%h ts=%h",
                           d, $time, act_c.rd, act_c.addr, act_c.busy, act_c.done, act_c.id_ok,
                           act_c.ts_ok, act_c.tmo, act_c.idv, act_c.tsv,
                           exp_o[d].rd, exp_o[d].addr, exp_o[d].busy, exp_o[d].done,
                           exp_o[d].id_ok, exp_o[d].ts_ok, exp_o[d].tmo, exp_o[d].idv, exp_o[d].tsv);
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      plan_t p;
      int done_r, rd_cnt, done_cnt, addr1_cnt, aborted;
      int pend_rst [2];
      for (int d = 0; d < 2; d++) begin
         reset_n[d] = 1'b0; start[d] = 1'b0;
         avm_waitrequest[d] = 1'b0; avm_readdata[d] = 32'd0;
         exp_o[d] = '0; hold[d] = '0; pend_rst[d] = 0;
      end
      repeat (2) @(posedge clock);
      #1;
      chk_en = 1'b1;
      reset_n[1] = 1'b1;

      // Model pins against hand-derived timelines.
      p = mk_plan(0, 0, 0, EID0, ETS0);
      lit("model_min_fin", 32'(p.fin), 32'd3);
      p = mk_plan(1, 5, 5, EID1, ETS1);
      lit("model_wait5_read_len", 32'(p.re0), 32'd6);
      lit("model_wait5_fin", 32'(p.fin), 32'd17);
      p = mk_plan(1, 20, 0, EID1, ETS1);
      lit("model_tmo_fin", 32'(p.fin), 32'd9);

      // Zero-wait slave, auto start out of reset.
      p = mk_plan(0, 0, 0, 32'h0000_0000, 32'd1480469370);
      run_trial(0, 1, p, 0, 0, done_r, rd_cnt, done_cnt, addr1_cnt, aborted);
      lit("t1_done_cycle", 32'(done_r), 32'd3);
      lit("t1_read_cycles", 32'(rd_cnt), 32'd2);
      lit("t1_ts_value", ts_value[0], 32'h583E_2B7A);
      lit("t1_flags", {29'd0, id_ok[0], ts_ok[0], timeout[0]}, 32'd6);

      // Timestamp off by one.
      p = mk_plan(0, 0, 0, 32'h0000_0000, 32'd1480469371);
      run_trial(0, 0, p, 0, 0, done_r, rd_cnt, done_cnt, addr1_cnt, aborted);
      lit("t2_ts_value", ts_value[0], 32'd1480469371);
      lit("t2_flags", {29'd0, id_ok[0], ts_ok[0], timeout[0]}, 32'd4);
      lit("t2_done_count", 32'(done_cnt), 32'd1);

      // Zero-latency instance: timeout on the second read.
      p = mk_plan(0, 2, 300, EID0, ETS0);
      run_trial(0, 0, p, 0, 0, done_r, rd_cnt, done_cnt, addr1_cnt, aborted);
      lit("t2b_timeout", {31'd0, timeout[0]}, 32'd1);

      // Five stall cycles per read with latency 2.
      p = mk_plan(1, 5, 5, EID1, ETS1);
      run_trial(1, 1, p, 0, 0, done_r, rd_cnt, done_cnt, addr1_cnt, aborted);
      lit("t3_read_cycles", 32'(rd_cnt), 32'd12);
      lit("t3_done_cycle", 32'(done_r), 32'd17);
      lit("t3_flags", {29'd0, id_ok[1], ts_ok[1], timeout[1]}, 32'd6);

      // Waitrequest stuck high.
      p = mk_plan(1, 40, 0, EID1, ETS1);
      run_trial(1, 0, p, 0, 0, done_r, rd_cnt, done_cnt, addr1_cnt, aborted);
      lit("t4_read_cycles", 32'(rd_cnt), 32'd8);
      lit("t4_addr1_reads", 32'(addr1_cnt), 32'd0);
      lit("t4_flags", {29'd0, id_ok[1], ts_ok[1], timeout[1]}, 32'd1);
      lit("t4_done_count", 32'(done_cnt), 32'd1);

      // Reset during the timestamp latency phase, then a fresh sequence.
      p = mk_plan(1, 1, 2, EID1, ETS1);
      run_trial(1, 0, p, p.dv1, 0, done_r, rd_cnt, done_cnt, addr1_cnt, aborted);
      lit("t5_abort_done_count", 32'(done_cnt), 32'd0);
      p = mk_plan(1, 0, 1, EID1, ETS1);
      run_trial(1, 1, p, 0, 0, done_r, rd_cnt, done_cnt, addr1_cnt, aborted);
      lit("t5_flags", {29'd0, id_ok[1], ts_ok[1], timeout[1]}, 32'd6);

      // Start pokes while busy and in the final cycle.
      p = mk_plan(0, 1, 0, EID0, ETS0);
      run_trial(0, 0, p, 0, 1, done_r, rd_cnt, done_cnt, addr1_cnt, aborted);
      lit("t6_done_count_dut0", 32'(done_cnt), 32'd1);
      p = mk_plan(1, 0, 3, EID1, ETS1);
      run_trial(1, 0, p, 0, 1, done_r, rd_cnt, done_cnt, addr1_cnt, aborted);
      lit("t6_done_count_dut1", 32'(done_cnt), 32'd1);

      // Randomized sequences on both instances.
      for (int t = 0; t < 60; t++) begin
         int d, w0, w1, launch, abort_r, poke;
         logic [31:0] d0, d1;
         d  = int'($urandom % 2);
         w0 = (d == 0) ? int'($urandom % 7) : int'($urandom % 11);
         w1 = (d == 0) ? int'($urandom % 7) : int'($urandom % 11);
         case ($urandom % 3)
            0: d0 = eid(d);
            1: d0 = eid(d) ^ (32'd1 << ($urandom % 32));
            default: d0 = $urandom;
         endcase
         case ($urandom % 3)
            0: d1 = ets(d);
            1: d1 = ets(d) ^ (32'd1 << ($urandom % 32));
            default: d1 = $urandom;
         endcase
         p = mk_plan(d, w0, w1, d0, d1);
         launch  = (pend_rst[d] != 0 || $urandom % 6 == 0) ? 1 : 0;
         abort_r = ($urandom % 8 == 0) ? 1 + int'($urandom % (p.fin - 1)) : 0;
         poke    = int'($urandom % 2);
         run_trial(d, launch, p, abort_r, poke, done_r, rd_cnt, done_cnt, addr1_cnt, aborted);
         lit("rand_done_count", 32'(done_cnt), (aborted != 0) ? 32'd0 : 32'd1);
         pend_rst[d] = aborted;
      end

      repeat (3) @(posedge clock);
      @(negedge clock);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
